// File: rtl/mem_access_ctrl.sv
// Sequencer that turns single-beat CPU loads/stores into SETUP/ACCESS/HOLD bus cycles
// for memory_io, with per-region wait states and suppression of ROM stores.
module mem_access_ctrl #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_err,
  output logic        read_memory,
  output logic        write_memory,
  output logic [15:0] address_out,
  inout  wire  [7:0]  internal_data_bus
);

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        drv_q, drv_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;
  logic        rvalid_q, rvalid_d;
  logic        rerr_q, rerr_d;
  logic [7:0]  rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    drv_d    = drv_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          drv_d   = req_write;
          err_d   = 1'b0;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = addr_q[15] ? RAM_W : ROM_W;
        err_d   = write_q & ~addr_q[15];
        rd_d    = ~write_q;
        // ROM stores get no strobe at all, so memory is never touched
        wr_d    = write_q & addr_q[15];
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = err_q;
          if (!write_q) rdata_d = internal_data_bus;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        drv_d   = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      write_q  <= 1'b0;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      drv_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      drv_q    <= drv_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready         = ready_q;
  assign resp_valid        = rvalid_q;
  assign resp_err          = rerr_q;
  assign resp_rdata        = rdata_q;
  assign read_memory       = rd_q;
  assign write_memory      = wr_q;
  assign address_out       = addr_q;
  assign internal_data_bus = drv_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Cycle-accurate bench for mem_access_ctrl: per-cycle strobe/address/bus checks plus a
// response scoreboard filled at acceptance and drained when resp_valid fires.
module tb_mem_access_ctrl;
  localparam int ROM_WAIT = 1;
  localparam int RAM_WAIT = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready, resp_valid, resp_err, read_memory, write_memory;
  logic [7:0]  resp_rdata;
  logic [15:0] address_out;
  wire  [7:0]  bus;
  logic [7:0]  dev_data;

  // external memory_io device answers loads while the read strobe is up
  assign bus = read_memory ? dev_data : 8'hzz;

  mem_access_ctrl #(.ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .read_memory(read_memory), .write_memory(write_memory),
    .address_out(address_out), .internal_data_bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [8:0] sb[$];
  logic [7:0] last_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (read_memory && write_memory) chk("strobe_overlap", 1, 0);
      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("resp_err", resp_err, e[8]);
          chk("resp_rdata", resp_rdata, e[7:0]);
        end
      end
    end
  end

  // Called in an IDLE cycle; returns in the IDLE cycle after HOLD.
  task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] dv, input bit hold_valid);
    int w;
    bit err;
    w = a[15] ? RAM_WAIT : ROM_WAIT;
    err = wr && !a[15];
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; dev_data = dv;
    tick();
    if (!wr) last_rdata = dv;
    sb.push_back({err, last_rdata});
    if (!hold_valid) req_valid = 1'b0;
    for (int c = 1; c <= w + 4; c++) begin
      chk("address_out", address_out, a);
      chk("read_memory", read_memory, !wr && c >= 2 && c <= w + 2);
      chk("write_memory", write_memory, wr && a[15] && c >= 2 && c <= w + 2);
      chk("resp_valid", resp_valid, c == w + 3);
      chk("req_ready", req_ready, c == w + 4);
      if (wr && c <= w + 3) chk("bus_wdata", bus, wd);
      if (c < w + 4) tick();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    dev_data = '0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 8'h00);
    chk("rst_rd", read_memory, 0);
    chk("rst_wr", write_memory, 0);
    chk("rst_addr", address_out, 16'h0000);
    #20 reset = 1'b0;
    tick();

    access(1'b0, 16'h8010, 8'h00, 8'h3C, 1'b0);   // RAM load
    access(1'b0, 16'h0040, 8'h00, 8'hC3, 1'b0);   // ROM load
    access(1'b1, 16'h8123, 8'h5A, 8'h00, 1'b0);   // RAM store
    access(1'b1, 16'h1234, 8'hFF, 8'h00, 1'b0);   // ROM store, suppressed
    access(1'b0, 16'h8000, 8'h00, 8'h96, 1'b1);   // back-to-back pair
    access(1'b1, 16'h8001, 8'h77, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      access(i[0], a, 8'($urandom), 8'($urandom), 1'b0);
    end

    // reset during the first read strobe cycle of a ROM load
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100; dev_data = 8'h11;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_rd_before", read_memory, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rd_drop", read_memory, 0);
    chk("mid_ready", req_ready, 1);
    chk("mid_resp_valid", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    last_rdata = 8'h00;
    tick();
    chk("post_rst_ready", req_ready, 1);
    access(1'b0, 16'h8F00, 8'h00, 8'hE1, 1'b0);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer that turns single-beat CPU load/store requests into correctly timed strobe, address and data activity for the `memory_io` bus stage directly downstream. It holds the address stable around the strobe and inserts per-region wait states: ROM is selected when address bit 15 = 0, RAM when bit 15 = 1. It drives or samples the shared 8-bit internal data bus and returns one response per request. Blocked accesses, meaning writes to ROM, are suppressed and flagged.

## Interface
Parameters:
- `ROM_WAIT`, default 1: extra strobe cycles for ROM accesses (0–15).
- `RAM_WAIT`, default 0: extra strobe cycles for RAM accesses (0–15).

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: CPU request present.
- `req_write`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, 16: byte address.
- `req_wdata`, input, 8: store data.
- `req_ready`, output, 1: controller idle; request accepted on an edge where `req_valid` and `req_ready` are both 1.
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_rdata`, output, 8: load data; valid while `resp_valid`, held until the next load completes.
- `resp_err`, output, 1: with `resp_valid`; store to ROM was suppressed.
- `read_memory`, output, 1: read strobe to `memory_io`.
- `write_memory`, output, 1: write strobe to `memory_io`.
- `address_out`, output, 16: address to `memory_io` `address_in`.
- `internal_data_bus`, inout, 8: driven only during store phases, otherwise high-Z; sampled for loads.

## Operation
- All outputs are registered.
- Request fields are latched on acceptance and are not sampled again.
- States are IDLE, SETUP, ACCESS, HOLD.
- **IDLE**
  - `req_ready` = 1, strobes 0, bus released.
  - On accept: latch addr, write and wdata, then go to SETUP.
- **SETUP** (1 cycle)
  - `address_out` = latched addr.
  - Store: bus driven with wdata.
  - Wait counter loaded with `ROM_WAIT` if addr[15] = 0, else `RAM_WAIT`.
  - Store to ROM sets an internal error flag.
- **ACCESS** (counter + 1 cycles)
  - Load: `read_memory` = 1.
  - Store to RAM: `write_memory` = 1.
  - Store to ROM: no strobe.
  - Counter decrements each cycle. When the counter = 0, go to HOLD; a load captures `internal_data_bus` into `resp_rdata` on that edge.
- **HOLD** (1 cycle)
  - Strobes 0; address and store data still driven (hold time).
  - `resp_valid` = 1; `resp_err` = error flag.
  - Next state is IDLE.
- Invariants:
  - `read_memory` and `write_memory` are never both 1.
  - `address_out` changes only on entry to SETUP.
  - The bus is never driven during a load.
- `resp_err` = 0 for every load and every RAM store. A ROM store with the flag set leaves memory untouched.
- `req_valid` while not ready is ignored; the CPU must hold it.

## Timing
- Reset values:
  - IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 8'h00.
  - `read_memory` = 0, `write_memory` = 0, `address_out` = 16'h0000, bus high-Z.
- Reset asserted mid-transaction: strobes drop and the bus releases immediately (asynchronous). No response is issued, and the first post-reset edge is in IDLE.
- Latency for an access with wait count W, counting cycles after the accepting edge:
  - SETUP = cycle 1.
  - ACCESS = cycles 2..W+2.
  - HOLD / `resp_valid` = cycle W+3.
  - `req_ready` = 1 in cycle W+4.
- Throughput: one access per W+4 cycles.
- Back-to-back: a request held high is accepted on the first edge of the IDLE cycle that follows HOLD.
- Strobe width is exactly W+1 cycles, with one address/data setup cycle before it and one hold cycle after.

## Test plan
- **RAM load, `RAM_WAIT` = 0:** accept addr 0x8010; external device returns 0x3C.
  - `address_out` = 0x8010 from cycle 1.
  - `read_memory` high in cycle 2 only.
  - `resp_valid` in cycle 3 with `resp_rdata` = 0x3C, `resp_err` = 0.
- **ROM load, `ROM_WAIT` = 1:** addr 0x0040, data 0xC3.
  - `read_memory` high in cycles 2–3.
  - `resp_valid` in cycle 4 with `resp_rdata` = 0xC3.
- **RAM store:** addr 0x8123, wdata 0x5A.
  - Bus = 0x5A in cycles 1–3.
  - `write_memory` high in cycle 2 only.
  - Bus high-Z in cycle 4, `resp_err` = 0.
- **ROM store:** addr 0x1234, wdata 0xFF.
  - No `write_memory` pulse at any point.
  - `resp_valid` with `resp_err` = 1 in cycle 4; `resp_rdata` unchanged.
- **Back-to-back:** `req_valid` held high across a RAM load to 0x8000 followed by a RAM store to 0x8001.
  - The second request is accepted the cycle after the first response.
  - `address_out` switches from 0x8000 to 0x8001 only at the second SETUP.
  - The strobes never overlap.
- **Reset mid-ACCESS (ROM load):** assert `reset` during the first strobe cycle.
  - `read_memory` falls within the same cycle and no `resp_valid` is issued.
  - After release, `req_ready` = 1 and a new RAM load completes normally.
